nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing the team's single 4-bit carry look-ahead unit (lookAhead: A[3:0], B[3:0], Cin -> carries C[3:0]), one nibble per cycle, LSB nibble first.
- Sits beside the ALU as the area-reduced adder path. Valid/ready on both the request side and the result side.

---
 rtl/nibble_serial_adder_ctrl.sv | 179 +++++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose     : WIDTH-bit add/subtract that reuses one 4-bit carry look-ahead stage, one nibble per cycle, LSB nibble first.
// Latency     : res_valid rises exactly NIB cycles after the accept edge; start_ready returns the cycle after the result handshake.
// Backpressure: valid/ready on both sides; result and flags hold while res_ready is low, and no new request is accepted until then.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start_valid/ready     request handshake; start_ready is high only in IDLE
//   op_sub, a_in, b_in    operation and operands, sampled on the accept edge
//   res_valid/ready       result handshake
//   result                WIDTH-bit sum or difference
//   carry_out             final carry (for subtract: 1 = no borrow)
//   overflow              two's-complement overflow
//   zero                  result == 0
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_res_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_handshake;
    logic [3:0]         w_c;
    logic [3:0]         w_cin_vec;
    logic [3:0]         w_sum;
    logic [WIDTH-1:0]   w_result_next;

    // Shared 4-bit carry look-ahead stage: C[i] is the carry out of bit i.
    function automatic logic [3:0] lookahead_carries(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = r_res_valid;
    assign result      = r_result;
    assign carry_out   = r_carry_out;
    assign overflow    = r_overflow;
    assign zero        = r_zero;

    assign w_accept    = start_valid && (r_state == ST_IDLE);
    assign w_last      = (r_state == ST_RUN) && (r_cnt == LAST_NIB);
    assign w_handshake = r_res_valid && res_ready;

    assign w_c       = lookahead_carries(r_a[3:0], r_b[3:0], r_carry);
    assign w_cin_vec = {w_c[2:0], r_carry};
    assign w_sum     = r_a[3:0] ^ r_b[3:0] ^ w_cin_vec;

    // Result with the current nibble merged in; the zero flag on the last
    // nibble must see this value, not the registered one.
    always_comb begin
        w_result_next = r_result;
        for (int n = 0; n < NIB; n++) begin
            if (r_cnt == CNT_W'(n)) begin
                w_result_next[n*4 +: 4] = w_sum;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_next_state = ST_RUN;
            ST_RUN:  if (w_last)      w_next_state = ST_DONE;
            ST_DONE: if (w_handshake) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a         <= a_in;
                        // Subtract is A + ~B + 1: invert B here, the +1
                        // enters as the initial carry.
                        r_b         <= op_sub ? ~b_in : b_in;
                        r_carry     <= op_sub;
                        r_cnt       <= '0;
                        r_res_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_c[3];
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_c[3];
                        // Carry into the MSB is C[2] of the top nibble.
                        r_overflow  <= w_c[3] ^ w_c[2];
                        r_zero      <= (w_result_next == '0);
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (w_handshake) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Purpose     : Self-checking bench for nibble_serial_adder_ctrl at WIDTH=32 and WIDTH=8.
// Latency     : Expects res_valid exactly WIDTH/4 cycles after the accept edge.
// Backpressure: Stalls res_ready and pokes the request side while a result waits.
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        op_sub;
    logic        res_ready;
    logic        sel8;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        s32_ready, rv32, co32, ov32, z32;
    logic [31:0] res32;
    logic        s8_ready, rv8, co8, ov8, z8;
    logic [7:0]  res8;

    logic        m_ready, m_valid, m_co, m_ov, m_z;
    logic [31:0] m_res;

    int n_chk;
    int n_pass;

    assign m_ready = sel8 ? s8_ready : s32_ready;
    assign m_valid = sel8 ? rv8      : rv32;
    assign m_co    = sel8 ? co8      : co32;
    assign m_ov    = sel8 ? ov8      : ov32;
    assign m_z     = sel8 ? z8       : z32;
    assign m_res   = sel8 ? {24'd0, res8} : res32;

    nibble_serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid & ~sel8),
        .start_ready (s32_ready),
        .op_sub      (op_sub),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (rv32),
        .res_ready   (res_ready & ~sel8),
        .result      (res32),
        .carry_out   (co32),
        .overflow    (ov32),
        .zero        (z32)
    );

    nibble_serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid & sel8),
        .start_ready (s8_ready),
        .op_sub      (op_sub),
        .a_in        (a_in[7:0]),
        .b_in        (b_in[7:0]),
        .res_valid   (rv8),
        .res_ready   (res_ready & sel8),
        .result      (res8),
        .carry_out   (co8),
        .overflow    (ov8),
        .zero        (z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on w-bit values.
    task automatic model(input int w, input logic sub, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic co, output logic ov, output logic z);
        logic [63:0] mask, aa, bb, full;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        full = aa + bb + {63'd0, sub};
        res  = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
        z    = (res == 32'd0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = mask;
            2:       v = 32'd1 << (w - 1);
            3:       v = mask >> 1;
            4:       v = 32'd1;
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    // One full operation on the selected DUT; all inputs driven at negedge.
    task automatic run_op(input int w, input logic sub, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eco, input logic eov, input logic ez,
                          input int stall, input bit poke);
        int guard;
        int lat;
        guard = 0;
        while (!m_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("start_ready_before_accept", 32'(m_ready), 32'd1);
        op_sub      = sub;
        a_in        = a;
        b_in        = b;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        a_in        = $urandom;
        b_in        = $urandom;
        op_sub      = 1'($urandom);
        lat = 0;
        while (!m_valid && lat < 40) begin
            res_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        res_ready = 1'b0;
        chk("accept_to_valid_cycles", lat, w / 4);
        if (!m_valid) return;
        chk("result",    m_res,       er);
        chk("carry_out", 32'(m_co),   32'(eco));
        chk("overflow",  32'(m_ov),   32'(eov));
        chk("zero",      32'(m_z),    32'(ez));
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                start_valid = 1'b1;
                a_in        = $urandom;
                b_in        = $urandom;
                op_sub      = 1'($urandom);
            end
            @(negedge clk);
            chk("stall_res_valid",   32'(m_valid), 32'd1);
            chk("stall_start_ready", 32'(m_ready), 32'd0);
            chk("stall_result",      m_res,        er);
            chk("stall_flags",       {29'd0, m_co, m_ov, m_z}, {29'd0, eco, eov, ez});
        end
        // With poke, start_valid coincides with the handshake edge and must be ignored.
        res_ready   = 1'b1;
        start_valid = poke;
        @(negedge clk);
        res_ready   = 1'b0;
        start_valid = 1'b0;
        chk("post_hs_res_valid",   32'(m_valid), 32'd0);
        chk("post_hs_start_ready", 32'(m_ready), 32'd1);
        chk("post_hs_result_held", m_res,        er);
        chk("post_hs_flags_held",  {29'd0, m_co, m_ov, m_z}, {29'd0, eco, eov, ez});
    endtask

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] er;
        logic        eco, eov, ez;
        logic [31:0] ra, rb;
        logic        rs;
        int          w;

        n_chk = 0;
        n_pass = 0;
        tbl[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst_n       = 1'b0;
        start_valid = 1'b0;
        op_sub      = 1'b0;
        res_ready   = 1'b0;
        sel8        = 1'b0;
        a_in        = 32'd0;
        b_in        = 32'd0;

        // Reset state on both widths.
        repeat (2) @(negedge clk);
        chk("rst_start_ready32", 32'(s32_ready), 32'd1);
        chk("rst_res_valid32",   32'(rv32),      32'd0);
        chk("rst_result32",      res32,          32'd0);
        chk("rst_flags32",       {29'd0, co32, ov32, z32}, 32'd0);
        chk("rst_start_ready8",  32'(s8_ready),  32'd1);
        chk("rst_res_valid8",    32'(rv8),       32'd0);
        chk("rst_result8",       {24'd0, res8},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_start_ready", 32'(s32_ready), 32'd1);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(32, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].co, tbl[i].ov, tbl[i].z, 0, 1'b0);
        end

        // Backpressure: 5 stalled cycles with request-side pokes.
        run_op(32, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 5, 1'b1);

        // Reset in the middle of a run.
        op_sub      = 1'b0;
        a_in        = 32'h1234_5678;
        b_in        = 32'h1111_1111;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_res_valid",   32'(rv32),      32'd0);
        chk("midrun_rst_result",      res32,          32'd0);
        chk("midrun_rst_start_ready", 32'(s32_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Random back-to-back traffic, both widths, against the model.
        for (int k = 0; k < 1000; k++) begin
            sel8 = (k >= 500);
            w    = sel8 ? 8 : 32;
            ra   = pick(w);
            rb   = pick(w);
            rs   = 1'($urandom);
            model(w, rs, ra, rb, er, eco, eov, ez);
            run_op(w, rs, ra, rb, er, eco, eov, ez, $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
